// File: rtl/icache_refill_bridge_pkg.sv
// Shared types and constants for the icache refill bridge.
// Holds the ISA word width, the NOP filler and the bridge FSM encoding.
package icache_refill_bridge_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;
  localparam int unsigned IRB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StResp  = 3'd3,
    StDrain = 3'd4
  } irb_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_last_buf.sv
// One-entry buffer holding the most recent successful refill word.
// Invalidate takes priority over a coincident write.
module ifetch_last_buf
  import icache_refill_bridge_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_addr,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_tag,
  input  logic [XLEN-1:0] wr_data,
  input  logic            inv,
  output logic            hit,
  output logic [XLEN-1:0] hit_data
);

  logic            valid_q;
  logic [XLEN-1:0] tag_q;
  logic [XLEN-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (inv) begin
        valid_q <= 1'b0;
      end else if (wr_en) begin
        valid_q <= 1'b1;
      end
      if (wr_en) begin
        tag_q  <= wr_tag;
        data_q <= wr_data;
      end
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/icache_refill_bridge.sv
// Bridges single-word icache refills onto a req/gnt/rvalid instruction bus,
// with a last-fetch buffer, alignment check, timeout and flush-abort draining.
module icache_refill_bridge
  import icache_refill_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = IRB_TIMEOUT_DEFAULT,
  parameter bit          BUF_EN         = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cache_req,
  input  logic [XLEN-1:0] cache_addr,
  input  logic            abort,
  input  logic            buf_inv,
  output logic            cache_ack,
  output logic [XLEN-1:0] cache_data,
  output logic            cache_err,
  output logic            bus_req,
  output logic [XLEN-1:0] bus_addr,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_err,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  irb_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;

  logic            buf_wr_en;
  logic            buf_hit;
  logic [XLEN-1:0] buf_hit_data;

  ifetch_last_buf u_last_buf (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (cache_addr),
    .wr_en       (buf_wr_en & BUF_EN),
    .wr_tag      (addr_q),
    .wr_data     (bus_rdata),
    .inv         (buf_inv),
    .hit         (buf_hit),
    .hit_data    (buf_hit_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    buf_wr_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cache_req && !abort) begin
          if (!is_word_aligned(cache_addr)) begin
            err_d   = 1'b1;
            data_d  = NOP_INSTRUCTION;
            to_d    = 1'b0;
            state_d = StResp;
          end else if (BUF_EN && buf_hit && !buf_inv) begin
            // A same-cycle invalidate turns a would-be hit into a miss
            err_d   = 1'b0;
            data_d  = buf_hit_data;
            to_d    = 1'b0;
            state_d = StResp;
          end else begin
            addr_d  = cache_addr;
            state_d = StReq;
          end
        end
      end

      StReq: begin
        if (bus_gnt) begin
          // Once granted the response must be consumed, even if aborted
          cnt_d   = '0;
          state_d = abort ? StDrain : StWait;
        end else if (abort || !cache_req) begin
          state_d = StIdle;
        end
      end

      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          buf_wr_en = !bus_err;
          if (abort) begin
            state_d = StIdle;
          end else begin
            data_d  = bus_err ? NOP_INSTRUCTION : bus_rdata;
            err_d   = bus_err;
            to_d    = 1'b0;
            state_d = StResp;
          end
        end else if (abort) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          data_d  = NOP_INSTRUCTION;
          to_d    = 1'b1;
          state_d = StResp;
        end
      end

      StResp: begin
        // After a timeout the late response may still arrive, so drain it
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = to_q ? StDrain : StIdle;
      end

      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid) begin
          buf_wr_en = !bus_err;
          state_d   = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= NOP_INSTRUCTION;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign cache_ack  = (state_q == StResp) && !abort;
  assign cache_data = data_q;
  assign cache_err  = err_q;
  assign bus_req    = (state_q == StReq);
  assign bus_addr   = addr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/icache_refill_bridge.md
Name: icache_refill_bridge

Overview:
- Sits between the icache refill port and the external instruction bus. It replaces the stub that acks every icache miss immediately with a NOP.
- Takes single-word refill requests from icache (mem_read/mem_addr). Issues them on a req/gnt/rvalid bus and returns data with a one-cycle ack.
- Holds a one-entry last-fetch buffer, checks alignment, enforces a timeout, and handles pipeline-flush aborts, including draining orphaned responses.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in WAIT or DRAIN before an error or forced return to IDLE; counter width is $clog2(TIMEOUT_CYCLES+1).
- BUF_EN, 1: 1 enables the last-fetch buffer; 0 means every request goes to the bus.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cache_req  in  1  refill request from icache; level, held until cache_ack.
- cache_addr  in  XLEN  refill word address; stable while cache_req is high.
- abort  in  1  flush from control_hazard; cancels the in-flight request.
- buf_inv  in  1  invalidate the last-fetch buffer (fence.i).
- cache_ack  out  1  one-cycle pulse; cache_data/cache_err valid.
- cache_data  out  XLEN  fetched word; NOP_INSTRUCTION when cache_err.
- cache_err  out  1  fetch failed: misaligned, bus error, or timeout.
- bus_req  out  1  bus request.
- bus_addr  out  XLEN  word-aligned bus address; stable while bus_req is high.
- bus_gnt  in  1  bus accepted the request this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read data.
- bus_err  in  1  qualifies bus_rvalid as an error response.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; buffer invalid; timeout counter=0.
  - cache_ack=0, cache_err=0, cache_data=NOP_INSTRUCTION, bus_req=0, bus_addr=0, busy=0.
- States: IDLE, REQ, WAIT, RESP, DRAIN. bus_req=1 only in REQ, decoded from state. cache_ack=1 only in RESP, and not when abort is high that cycle.
- IDLE, when cache_req=1 and abort=0, checks in this order:
  - cache_addr[1:0]!=0: latch err, data=NOP, go to RESP. No bus access.
  - BUF_EN, buffer valid, and tag==cache_addr: latch buffer data, go to RESP. Hit latency is 1: req in cycle 0, ack in cycle 1.
  - Otherwise: latch bus_addr=cache_addr, go to REQ.
- REQ:
  - bus_gnt=1: go to WAIT and clear the counter.
  - abort=1 or cache_req=0 before gnt: go to IDLE. The bus permits retraction before gnt.
  - If abort and gnt occur in the same cycle, gnt wins and the FSM goes to DRAIN.
- WAIT:
  - The counter increments each cycle.
  - bus_rvalid=1: latch data and err=bus_err, then go to RESP. If err=0, write buffer {tag=bus_addr, data, valid=1}.
  - abort=1 without rvalid: go to DRAIN and clear the counter.
  - abort and rvalid in the same cycle: update the buffer if no error, go to IDLE, no ack.
  - Counter reaches TIMEOUT_CYCLES: err=1, data=NOP, go to RESP, then to DRAIN instead of IDLE.
- RESP: lasts one cycle, then goes to IDLE (or DRAIN after a timeout). cache_req high in the following IDLE cycle is a new request.
- DRAIN:
  - No acks. cache_req is ignored (busy=1).
  - bus_rvalid: update the buffer if bus_err=0, then go to IDLE.
  - Counter reaches TIMEOUT_CYCLES: go to IDLE.
- Miss latency: req in cycle 0, bus_req in cycle 1; gnt in cycle g, rvalid in cycle r>g; ack in cycle r+1.
- buf_inv clears the valid bit next edge in any state. If buf_inv coincides with a buffer write, the invalidate wins. A buf_inv in IDLE in the same cycle as a request forces a miss.
- Only one transaction is outstanding on the bus at any time.
- abort in IDLE has no effect. If abort coincides with a new cache_req, the request is dropped.

Decomposition:
- Add to isa.v:
  - `IRB_ST_IDLE/REQ/WAIT/RESP/DRAIN` 3-bit encodings.
  - `IRB_TIMEOUT_DEFAULT` = 64.
- Reuse the existing `XLEN` and `NOP_INSTRUCTION`.
- One sub-module, ifetch_last_buf. It holds the tag/data/valid registers and contains:
  - a combinational hit compare;
  - a write port;
  - an invalidate input with priority over write;
  - the same async active-low reset.

Test Plan:
- Miss then hit: req addr 0x100, gnt in cycle 1, rvalid in cycle 4 with rdata 0x00500093 → ack in cycle 5 with data 0x00500093, err=0. Repeat addr 0x100 → ack 1 cycle after req, no bus_req.
- Misaligned: req addr 0x102 → ack next cycle, err=1, data=0x00000013, bus_req never high.
- Bus error: rvalid with bus_err=1 for addr 0x200 → ack, err=1. Re-request 0x200 → bus_req asserted again; the failed fetch was not buffered.
- Abort in WAIT: abort 2 cycles after gnt, rvalid 3 cycles later with 0xDEADBEEF → no ack, busy=1 until rvalid, then IDLE. A request for the same addr then hits the buffer.
- Timeout with TIMEOUT_CYCLES=8: gnt, no rvalid → ack err=1 after 8 WAIT cycles, then DRAIN for 8 cycles, then IDLE; a new req is accepted.
- buf_inv and reset: after a hit on 0x100, pulse buf_inv → next req 0x100 goes to the bus. Assert reset mid-WAIT → all outputs are 0, cache_data is NOP, the buffer is invalid, and the FSM is in IDLE.
